avl_bram_responder: RTL and testbench

//  Responder (slave) end of the Avalon-style memory port that the SDRAM/LPDDR

---
 rtl/avl_bram_responder.sv | 177 +++++++++++++++++
 tb/tb_avl_bram_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/avl_bram_responder.sv
// Block-RAM responder for the Avalon-style DDR controller port: fixed-latency reads,
// byte-enabled writes, bounded outstanding reads and a power-up init window.
module avl_bram_responder #(
    parameter int MEM_AW          = 12,
    parameter int READ_LATENCY    = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int INIT_CYCLES     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        avl_read_req,
    input  logic        avl_write_req,
    input  logic [29:0] avl_addr,
    input  logic [31:0] avl_wdata,
    input  logic [3:0]  avl_be,
    output logic        avl_ready,
    output logic [31:0] avl_rdata,
    output logic        avl_rdata_valid,
    output logic        local_init_done,
    output logic        proto_err
);

    localparam int IW   = $clog2(INIT_CYCLES + 1);
    localparam int CW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int DSTG = (READ_LATENCY > 2) ? READ_LATENCY - 2 : 1;
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
    localparam logic [CW-1:0] MAX_OUT   = CW'(MAX_OUTSTANDING);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     init_cnt_q, init_cnt_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              perr_q, perr_d;
    logic              valid_q, valid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [READ_LATENCY-2:0] vpipe_q, vpipe_d;
    logic              oor0_q, oor0_d;
    logic [31:0]       dpipe_q [1:DSTG];
    logic [31:0]       dpipe_d [1:DSTG];
    logic [31:0]       stage_s [0:READ_LATENCY-2];
    logic [31:0]       ram_rd_q;
    logic [31:0]       mem_q [0:(2**MEM_AW)-1];

    logic [MEM_AW-1:0] word_s;
    logic              oor_s;
    logic              acc_s;
    logic              rd_acc_s;
    logic              wr_en_s;
    logic              addr_lsb_unused_s;

    assign word_s            = avl_addr[MEM_AW+1:2];
    assign oor_s             = |avl_addr[29:MEM_AW+2];
    assign addr_lsb_unused_s = ^avl_addr[1:0];
    assign acc_s             = ready_q && (avl_read_req || avl_write_req);
    // A simultaneous read+write keeps the write and drops the read.
    assign rd_acc_s          = acc_s && avl_read_req && !avl_write_req;
    assign wr_en_s           = acc_s && avl_write_req && !oor_s;

    // Next-state: init FSM, outstanding count, read-return pipeline and outputs.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + {{(IW-1){1'b0}}, 1'b1};
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase

        case ({rd_acc_s, valid_q})
            2'b10:   outst_d = outst_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   outst_d = outst_q - {{(CW-1){1'b0}}, 1'b1};
            default: outst_d = outst_q;
        endcase

        // Ready looks at the post-update count so a freed slot is usable next cycle.
        done_d  = (state_d == ST_RUN);
        ready_d = (state_d == ST_RUN) && (outst_d < MAX_OUT);
        perr_d  = perr_q || (acc_s && avl_read_req && avl_write_req);

        stage_s[0] = oor0_q ? 32'hFFFF_FFFF : ram_rd_q;
        for (int k = 1; k <= READ_LATENCY - 2; k++) begin
            stage_s[k] = dpipe_q[k];
        end

        vpipe_d    = vpipe_q;
        vpipe_d[0] = rd_acc_s;
        for (int k = 1; k <= READ_LATENCY - 2; k++) begin
            vpipe_d[k] = vpipe_q[k-1];
        end

        for (int k = 1; k <= DSTG; k++) begin
            dpipe_d[k] = dpipe_q[k];
        end
        for (int k = 1; k <= READ_LATENCY - 2; k++) begin
            dpipe_d[k] = stage_s[k-1];
        end

        if (rd_acc_s) begin
            oor0_d = oor_s;
        end else begin
            oor0_d = oor0_q;
        end

        valid_d = vpipe_q[READ_LATENCY-2];
        if (vpipe_q[READ_LATENCY-2]) begin
            rdata_d = stage_s[READ_LATENCY-2];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State and output registers; reset flushes in-flight reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            outst_q    <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            perr_q     <= 1'b0;
            valid_q    <= 1'b0;
            rdata_q    <= 32'h0000_0000;
            vpipe_q    <= '0;
            oor0_q     <= 1'b0;
            for (int k = 1; k <= DSTG; k++) begin
                dpipe_q[k] <= 32'h0000_0000;
            end
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            outst_q    <= outst_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            perr_q     <= perr_d;
            valid_q    <= valid_d;
            rdata_q    <= rdata_d;
            vpipe_q    <= vpipe_d;
            oor0_q     <= oor0_d;
            for (int k = 1; k <= DSTG; k++) begin
                dpipe_q[k] <= dpipe_d[k];
            end
        end
    end

    // Backing RAM: byte-lane writes and registered read; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int b = 0; b < 4; b++) begin
                if (avl_be[b]) begin
                    mem_q[word_s][8*b +: 8] <= avl_wdata[8*b +: 8];
                end
            end
        end
        if (rd_acc_s) begin
            ram_rd_q <= mem_q[word_s];
        end
    end

    assign avl_ready       = ready_q;
    assign avl_rdata       = rdata_q;
    assign avl_rdata_valid = valid_q;
    assign local_init_done = done_q;
    assign proto_err       = perr_q;

endmodule

// File: tb/tb_avl_bram_responder.sv
// Self-checking bench for avl_bram_responder: directed steps plus random traffic
// checked every cycle against a queue-based reference model.
module tb_avl_bram_responder;

    localparam int L     = 4;
    localparam int MAXO  = 4;
    localparam int INITC = 16;

    typedef struct {
        int          due;
        logic [31:0] data;
    } ret_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        avl_read_req, avl_write_req;
    logic [29:0] avl_addr;
    logic [31:0] avl_wdata;
    logic [3:0]  avl_be;
    logic        avl_ready, avl_rdata_valid, local_init_done, proto_err;
    logic [31:0] avl_rdata;

    always #5 clk = ~clk;

    avl_bram_responder dut (
        .clk(clk), .reset(reset),
        .avl_read_req(avl_read_req), .avl_write_req(avl_write_req),
        .avl_addr(avl_addr), .avl_wdata(avl_wdata), .avl_be(avl_be),
        .avl_ready(avl_ready), .avl_rdata(avl_rdata), .avl_rdata_valid(avl_rdata_valid),
        .local_init_done(local_init_done), .proto_err(proto_err)
    );

    int          tests = 0;
    int          fails = 0;
    int          cyc;
    int          accepts;
    int          valids_seen;
    logic [31:0] last_rd;
    logic        perr_m;
    logic [31:0] mem_m [0:4095];
    ret_t        q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, then drive this cycle's request.
    task automatic step(input bit rd, input bit wr, input logic [29:0] addr,
                        input logic [31:0] wd, input logic [3:0] be);
        bit   rdy_e, acc, oor;
        int   w;
        ret_t r;
        rdy_e = (cyc >= INITC) && (q.size() < MAXO);
        chk("ready", {31'd0, avl_ready}, {31'd0, rdy_e});
        chk("init_done", {31'd0, local_init_done}, {31'd0, (cyc >= INITC)});
        chk("proto_err", {31'd0, proto_err}, {31'd0, perr_m});
        if (q.size() != 0 && q[0].due == cyc) begin
            chk("rdata_valid", {31'd0, avl_rdata_valid}, 32'd1);
            last_rd = q[0].data;
            void'(q.pop_front());
        end else begin
            chk("rdata_valid", {31'd0, avl_rdata_valid}, 32'd0);
        end
        chk("rdata", avl_rdata, last_rd);
        if (avl_rdata_valid === 1'b1) valids_seen++;

        avl_read_req  = rd;
        avl_write_req = wr;
        avl_addr      = addr;
        avl_wdata     = wd;
        avl_be        = be;
        acc = rdy_e && (rd || wr);
        w   = int'(addr[13:2]);
        oor = (addr[29:14] != 16'h0);
        if (acc && rd && !wr) begin
            r.due  = cyc + L;
            r.data = oor ? 32'hFFFF_FFFF : mem_m[w];
            q.push_back(r);
            accepts++;
        end
        if (acc && rd && wr) perr_m = 1'b1;
        if (acc && wr && !oor) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_m[w][8*b +: 8] = wd[8*b +: 8];
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        avl_read_req  = 1'b0;
        avl_write_req = 1'b0;
        avl_addr      = 30'h0;
        avl_wdata     = 32'h0;
        avl_be        = 4'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        cyc     = 0;
        q.delete();
        perr_m  = 1'b0;
        last_rd = 32'h0;
    endtask

    initial begin
        logic [29:0] a;
        logic [31:0] d;
        int          sel;

        accepts     = 0;
        valids_seen = 0;

        // 1: init window
        do_reset();
        idle(INITC + 1);

        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            step(1'b0, 1'b1, 30'(i * 4), d, 4'hF);
        end

        // 2: byte-lane merge then read back
        step(1'b0, 1'b1, 30'h40, 32'h1234_5678, 4'hF);
        step(1'b0, 1'b1, 30'h40, 32'h0000_00AB, 4'h1);
        step(1'b1, 1'b0, 30'h40, 32'h0, 4'h0);
        idle(L + 1);
        chk("t2_merge", avl_rdata, 32'h1234_56AB);

        // 3: out-of-range read and write
        step(1'b0, 1'b1, 30'h0, 32'h600D_F00D, 4'hF);
        step(1'b1, 1'b0, 30'h0100_0000, 32'h0, 4'h0);
        idle(L + 1);
        chk("t3_oor_read", avl_rdata, 32'hFFFF_FFFF);
        step(1'b0, 1'b1, 30'h0100_0000, 32'hDEAD_BEEF, 4'hF);
        step(1'b1, 1'b0, 30'h0, 32'h0, 4'h0);
        idle(L + 1);
        chk("t3_word0", avl_rdata, 32'h600D_F00D);

        // 4: continuous reads
        accepts     = 0;
        valids_seen = 0;
        for (int i = 0; i < MAXO; i++) step(1'b1, 1'b0, 30'(i * 4), 32'h0, 4'h0);
        chk("t4_ready_drop", {31'd0, avl_ready}, 32'd0);
        for (int i = 0; i < 24; i++) step(1'b1, 1'b0, 30'((i % 16) * 4), 32'h0, 4'h0);
        idle(L + 2);
        chk("t4_valid_count", 32'(valids_seen), 32'(accepts));

        // 5: read and write together
        step(1'b1, 1'b1, 30'h80, 32'h5A5A_5A5A, 4'hF);
        idle(L + 2);
        chk("t5_proto_err", {31'd0, proto_err}, 32'd1);
        step(1'b1, 1'b0, 30'h80, 32'h0, 4'h0);
        idle(L + 1);
        chk("t5_written", avl_rdata, 32'h5A5A_5A5A);

        // random traffic over pre-written words plus out-of-range hits
        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(15, 0));
            a   = 30'(sel * 4) | 30'($urandom_range(3, 0));
            if ($urandom_range(9, 0) == 0) a = a | (30'h1 << $urandom_range(29, 14));
            d   = $urandom;
            case ($urandom_range(3, 0))
                0:       step(1'b0, 1'b1, a, d, 4'($urandom_range(15, 0)));
                1, 2:    step(1'b1, 1'b0, a, d, 4'h0);
                default: step(1'b0, 1'b0, a, d, 4'h0);
            endcase
        end
        idle(L + 2);

        // 6: reset with reads in flight
        step(1'b1, 1'b0, 30'h4, 32'h0, 4'h0);
        step(1'b1, 1'b0, 30'h8, 32'h0, 4'h0);
        idle(2);
        do_reset();
        chk("t6_proto_clear", {31'd0, proto_err}, 32'd0);
        valids_seen = 0;
        idle(INITC + 4);
        chk("t6_no_valid", 32'(valids_seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
